// File: rtl/floating_point_division_if.sv
// Operand/result bus for the single-precision divider.
// The master side supplies operands; the slave side is the divider.
interface floating_point_division_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        out_valid;
    logic [31:0] quotient;
    logic        div_by_zero;

    modport master (
        output in_valid, input_a, input_b,
        input  in_ready, out_valid, quotient, div_by_zero
    );

    modport slave (
        input  in_valid, input_a, input_b,
        output in_ready, out_valid, quotient, div_by_zero
    );
endinterface

// File: rtl/floating_point_division.sv
// Sequential binary32 divider: radix-2 restoring mantissa loop (one quotient
// bit per cycle), round-to-nearest-even, denormals flushed to zero.
module floating_point_division (
    input  logic                        clk,
    input  logic                        rst_n,
    floating_point_division_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    // Control state (reset)
    state_t              state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         result_q, result_d;
    logic                dbz_q, dbz_d;

    // Datapath state (no reset)
    logic [24:0]         rem_q, rem_d;
    logic [25:0]         quo_q, quo_d;
    logic [23:0]         mb_q, mb_d;
    logic signed [9:0]   ediff_q, ediff_d;
    logic                sign_q, sign_d;

    // Operand decode
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea = bus.input_a[30:23];
    assign eb = bus.input_b[30:23];
    assign fa = bus.input_a[22:0];
    assign fb = bus.input_b[22:0];

    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    // One restoring step: subtract divisor if it fits, then shift for next bit
    logic [25:0] trial;
    logic        qbit;
    logic [24:0] kept;

    assign trial = {1'b0, rem_q} - {2'b00, mb_q};
    assign qbit  = ~trial[25];
    assign kept  = qbit ? trial[24:0] : rem_q;

    // Normalise the 26-bit quotient, round to nearest-even and pack, with
    // overflow to infinity and underflow flushed to signed zero.
    function automatic logic [31:0] round_pack(
        input logic              sign,
        input logic signed [9:0] ediff,
        input logic [25:0]       q,
        input logic              rem_nz
    );
        logic [23:0]       m;
        logic [24:0]       m_inc;
        logic              g;
        logic              s;
        logic signed [9:0] e;
        if (q[25]) begin
            m = q[25:2];
            g = q[1];
            s = q[0] | rem_nz;
            e = ediff + 10'sd127;
        end else begin
            m = q[24:1];
            g = q[0];
            s = rem_nz;
            e = ediff + 10'sd126;
        end
        if (g && (s || m[0])) begin
            m_inc = {1'b0, m} + 25'd1;
            if (m_inc[24]) begin
                m = 24'h800000;
                e = e + 10'sd1;
            end else begin
                m = m_inc[23:0];
            end
        end
        if (e >= 10'sd255)
            round_pack = {sign, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            round_pack = {sign, 31'd0};
        else
            round_pack = {sign, e[7:0], m[22:0]};
    endfunction

    // Next-state and datapath update for the IDLE/DIVIDE/ROUND/DONE sequence
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        dbz_d       = dbz_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        mb_d        = mb_q;
        ediff_d     = ediff_q;
        sign_d      = sign_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.input_a[31] ^ bus.input_b[31];
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result_d    = 32'h7FC00000;
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (a_inf) begin
                        result_d    = {sign_d, 8'hFF, 23'd0};
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (b_zero) begin
                        // a is finite and nonzero here
                        result_d    = {sign_d, 8'hFF, 23'd0};
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (a_zero || b_inf) begin
                        result_d    = {sign_d, 31'd0};
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = {2'b01, fa};
                        mb_d    = {1'b1, fb};
                        quo_d   = 26'd0;
                        ediff_d = $signed({2'b00, ea}) - $signed({2'b00, eb});
                        count_d = 5'd0;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                quo_d   = {quo_q[24:0], qbit};
                rem_d   = kept << 1;
                count_d = count_q + 5'd1;
                if (count_q == 5'd25)
                    state_d = ROUND;
            end
            ROUND: begin
                result_d    = round_pack(sign_q, ediff_q, quo_q, rem_q != 25'd0);
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
        end
    end

    // Datapath registers; only meaningful while a division is in flight
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        mb_q    <= mb_d;
        ediff_q <= ediff_d;
        sign_q  <= sign_d;
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_floating_point_division.sv
// Directed bench for the binary32 divider: vector table plus handshake and
// mid-operation reset sequences.
module tb_floating_point_division;
    logic clk;
    logic rst_n;

    floating_point_division_if bus();

    floating_point_division dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one operand pair, wait for the strobe and check the result
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic exp_dbz,
                           input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.input_a  = a;
        bus.input_b  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, "_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_quotient"}, bus.quotient, exp_q);
        chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dbz});
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int   lowcnt;
        int   lat;
        logic seen;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28};
        vecs[1]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1};
        vecs[7]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28};
        vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28};
        vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1};
        vecs[10] = '{32'h40000000, 32'h80000000, 32'hFF800000, 1'b1, 1};
        vecs[11] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1};
        vecs[12] = '{32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 1};
        vecs[13] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1};
        vecs[14] = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 1'b0, 28};
        vecs[15] = '{32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, 28};
        vecs[16] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1};
        vecs[17] = '{32'hFFC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.input_a  = 32'd0;
        bus.input_b  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_quotient", bus.quotient, 32'd0);
        chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            run_one(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, vecs[i].lat,
                    $sformatf("vec%0d", i));

        // Continuous in_valid with changing operands: only IDLE accepts count
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.input_a  = 32'h40C00000;
        bus.input_b  = 32'h40000000;
        @(posedge clk);
        #1;
        lowcnt = 0;
        for (int k = 0; k < 28; k++) begin
            if (!bus.in_ready) lowcnt++;
            if (k < 27) begin
                @(negedge clk);
                bus.input_a = 32'h3F800000 + (k * 32'h00011000);
                bus.input_b = 32'h40400000 + (k * 32'h00000100);
                @(posedge clk);
                #1;
            end
        end
        chk("hs_ready_low_cycles", lowcnt, 28);
        chk("hs_first_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hs_first_quotient", bus.quotient, 32'h40400000);
        @(negedge clk);
        bus.input_a = 32'h40E00000;
        bus.input_b = 32'h40000000;
        @(posedge clk);
        #1;
        chk("hs_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("hs_second_accept", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.input_a  = 32'h3F800000;
        bus.input_b  = 32'h3F800000;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hs_second_latency", lat, 28);
        chk("hs_second_quotient", bus.quotient, 32'h40600000);
        @(posedge clk);
        #1;

        // Reset at DIVIDE count 10 aborts the division
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.input_a  = 32'h40C00000;
        bus.input_b  = 32'h40000000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_quotient_cleared", bus.quotient, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_strobe", {31'd0, seen}, 32'd0);
        run_one(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/floating_point_division.md
# floating_point_division

Sequential IEEE-754 single-precision divider; the inverse-operation companion to `floating_point_multiplication` in the same FP datapath. It accepts one dividend/divisor pair through a valid/ready handshake and computes the mantissa quotient with a radix-2 restoring loop, one quotient bit per cycle. It then rounds to nearest-even and presents a one-cycle result strobe. Denormals are flushed to zero on input and output.

## Interface
- No parameters; the format is fixed at binary32.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands present
- in_ready  output  1  block idle and able to accept operands
- input_a  input  32  dividend, binary32
- input_b  input  32  divisor, binary32
- out_valid  output  1  one-cycle result strobe
- quotient  output  32  result; holds its value until the next result
- div_by_zero  output  1  finite nonzero / zero; valid with out_valid

## Operation
- States: IDLE, DIVIDE, ROUND, DONE.
- in_ready = (state == IDLE).
- Accept when in_valid && in_ready at a clock edge; operands are latched on that edge. in_valid is ignored outside IDLE.
- Decode:
  - exp == 0 → zero.
  - exp == 255 and frac == 0 → inf.
  - exp == 255 and frac != 0 → NaN.
  - Otherwise normal, mantissa = {1, frac} (24 bits).
- Sign = sa ^ sb. The sign applies to every result except NaN.
- Special cases go IDLE → DONE:
  - NaN operand, 0/0, or inf/inf → 32'h7FC00000.
  - inf/x → signed inf.
  - x/0 (x finite nonzero) → signed inf, div_by_zero = 1.
  - 0/x or x/inf → signed zero.
- Normal path: IDLE → DIVIDE.
  - DIVIDE runs 26 iterations: q = floor((ma << 25) / mb), 26 bits, plus remainder r.
  - The counter counts 0..25; the DIVIDE → ROUND transition occurs on count 25.
- ROUND:
  - If q[25] = 1: m = q[25:2], g = q[1], s = q[0] | (r != 0), e = ea − eb + 127.
  - Else: m = q[24:1], g = q[0], s = (r != 0), e = ea − eb + 126.
  - Round up when g && (s || m[0]).
  - If the mantissa carries out: m = 24'h800000, e = e + 1.
  - Compute e in 10-bit signed arithmetic.
  - e ≥ 255 → signed inf.
  - e ≤ 0 → signed zero (flush).
  - Else {sign, e[7:0], m[22:0]}.
- DONE: out_valid = 1 for exactly one cycle, quotient and div_by_zero updated, then → IDLE.
- div_by_zero is 0 for every non-x/0 result.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, quotient = 32'h0, div_by_zero = 0.
- Reset mid-operation aborts the computation; no out_valid follows.
- Latency, counted from the accept edge to the out_valid-high cycle:
  - Special case: out_valid is high in the cycle after the accept edge (1 cycle).
  - Normal: 26 DIVIDE cycles + 1 ROUND cycle + DONE gives out_valid high 28 cycles after the accept edge.
- in_ready is low from the accept edge through the DONE cycle. A new accept is possible on the edge that ends DONE + 1, i.e. back-to-back initiation interval is 29 cycles (normal) or 2 cycles (special).
- out_valid is registered. There is no backpressure; a consumer that misses the strobe reads quotient, which is held.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → quotient 0x40400000, out_valid exactly 28 cycles after accept, single-cycle pulse. Same with a = 0xC0C00000 → 0xC0400000.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB (round-up path). 0x3F800000 / 0x3F800000 → 0x3F800000 (q[25] = 1 path).
- 0x3F800000 / 0x00000000 → 0x7F800000, div_by_zero = 1, latency 1. 0x00000000 / 0x00000000 → 0x7FC00000, div_by_zero = 0. 0x7F800000 / 0x7F800000 → 0x7FC00000.
- Overflow: 0x7F000000 / 0x3E800000 → 0x7F800000. Underflow: 0x00800000 / 0x40000000 → 0x00000000. Denormal input 0x00000001 / 0x3F800000 → 0x00000000.
- Handshake: hold in_valid high continuously with changing operands. Only the operands present at each IDLE accept are used, and in_ready stays low for 28 cycles after each accept.
- Drive rst_n low at DIVIDE count 10 → no out_valid, in_ready = 1 on the next cycle. A fresh 6.0/2.0 afterwards returns the correct result.
